// File: rtl/if_id_stage.sv
// Fetch front end: program counter, instruction-memory address and the IF/ID latch.
// Optional performance counters are enabled with `define IF_ID_PERF_CNT_EN.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out,
    output logic [31:0] stall_cnt,
    output logic [31:0] redirect_cnt
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    // Redirect outranks stall so a taken branch is never lost behind a hazard.
    always_comb begin
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        if (redirect) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            pc_out_d = 32'h0000_0000;
            instr_d  = NOP_INSTR;
            valid_d  = 1'b0;
        end else if (!stall) begin
            pc_d     = pc_q + 32'd4;
            pc_out_d = pc_q;
            instr_d  = imem_rdata;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            pc_out_q <= 32'h0000_0000;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    assign imem_addr       = pc_q;
    assign pc_out          = pc_out_q;
    assign instruction_out = instr_q;
    assign valid_out       = valid_q;

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        if (redirect && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 32'd1;
        end
        if (stall && !redirect && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q    <= 32'h0000_0000;
            redirect_cnt_q <= 32'h0000_0000;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
`else
    assign stall_cnt    = 32'h0000_0000;
    assign redirect_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed vector table, hand sequences and
// randomized stimulus against a behavioural fetch model.
module tb_if_id_stage;

    localparam logic [31:0] Nop = 32'h0000_0013;
    localparam logic [31:0] Key = 32'hA5A5_0000;
`ifdef IF_ID_PERF_CNT_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_rdata, pc_out, instruction_out, stall_cnt, redirect_cnt;
    logic        valid_out;

    assign imem_rdata = imem_addr ^ Key;

    if_id_stage u_dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out),
        .stall_cnt       (stall_cnt),
        .redirect_cnt    (redirect_cnt)
    );

    // Second instance exercises the PC wrap from a high reset vector.
    logic        rst_w;
    logic [31:0] w_addr, w_rdata, w_pc_out, w_instr, w_scnt, w_rcnt;
    logic        w_valid;
    assign w_rdata = w_addr ^ Key;

    if_id_stage #(
        .RESET_PC  (32'hFFFF_FFF8),
        .NOP_INSTR (Nop)
    ) u_wrap (
        .clk             (clk),
        .rst             (rst_w),
        .imem_addr       (w_addr),
        .imem_rdata      (w_rdata),
        .stall           (1'b0),
        .redirect        (1'b0),
        .redirect_pc     (32'h0000_0000),
        .pc_out          (w_pc_out),
        .instruction_out (w_instr),
        .valid_out       (w_valid),
        .stall_cnt       (w_scnt),
        .redirect_cnt    (w_rcnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Behavioural model: fetch address, latched record and event counts.
    logic [31:0] m_pc, m_pc_out, m_instr;
    logic        m_valid;
    longint      m_scnt, m_rcnt;

    task automatic model_reset();
        m_pc = 32'h0; m_pc_out = 32'h0; m_instr = Nop; m_valid = 1'b0;
        m_scnt = 0; m_rcnt = 0;
    endtask

    task automatic model_edge();
        if (redirect) begin
            m_rcnt = m_rcnt + 1;
            m_pc = redirect_pc & ~32'd3;
            m_pc_out = 32'h0; m_instr = Nop; m_valid = 1'b0;
        end else if (stall) begin
            m_scnt = m_scnt + 1;
        end else begin
            m_pc_out = m_pc;
            m_instr  = m_pc ^ Key;
            m_valid  = 1'b1;
            m_pc     = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        end
        if (m_scnt > 64'hFFFF_FFFF) m_scnt = 64'hFFFF_FFFF;
        if (m_rcnt > 64'hFFFF_FFFF) m_rcnt = 64'hFFFF_FFFF;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".addr"},  imem_addr, m_pc);
        check({tag, ".pc"},    pc_out, m_pc_out);
        check({tag, ".instr"}, instruction_out, m_instr);
        check({tag, ".valid"}, {31'h0, valid_out}, {31'h0, m_valid});
        check({tag, ".scnt"},  stall_cnt, Perf ? 32'(m_scnt) : 32'h0);
        check({tag, ".rcnt"},  redirect_cnt, Perf ? 32'(m_rcnt) : 32'h0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        model_reset();
        #12;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] pc_out;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] addr;
        int unsigned scnt;
        int unsigned rcnt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        rst_w = 1'b1;
        vecs[0]  = '{1'b0, 1'b0, 32'h0,   32'h0,   Key ^ 32'h0,   1'b1, 32'h4,   0, 0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,   32'h4,   Key ^ 32'h4,   1'b1, 32'h8,   0, 0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,   32'h4,   Key ^ 32'h4,   1'b1, 32'h8,   1, 0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,   32'h4,   Key ^ 32'h4,   1'b1, 32'h8,   2, 0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,   32'h4,   Key ^ 32'h4,   1'b1, 32'h8,   3, 0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,   32'h8,   Key ^ 32'h8,   1'b1, 32'hC,   3, 0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,   32'hC,   Key ^ 32'hC,   1'b1, 32'h10,  3, 0};
        vecs[7]  = '{1'b1, 1'b1, 32'h103, 32'h0,   Nop,           1'b0, 32'h100, 3, 1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,   32'h100, Key ^ 32'h100, 1'b1, 32'h104, 3, 1};
        vecs[9]  = '{1'b0, 1'b1, 32'h200, 32'h0,   Nop,           1'b0, 32'h200, 3, 2};
        vecs[10] = '{1'b0, 1'b1, 32'h300, 32'h0,   Nop,           1'b0, 32'h300, 3, 3};
        vecs[11] = '{1'b0, 1'b0, 32'h0,   32'h300, Key ^ 32'h300, 1'b1, 32'h304, 3, 3};

        // Reset state before the first edge.
        do_reset();
        check("rst.valid", {31'h0, valid_out}, 32'h0);
        check("rst.instr", instruction_out, Nop);
        check("rst.pc", pc_out, 32'h0);
        check("rst.addr", imem_addr, 32'h0);
        check("rst.scnt", stall_cnt, 32'h0);
        check("rst.rcnt", redirect_cnt, 32'h0);

        for (int i = 0; i < 12; i++) begin
            stall = vecs[i].stall; redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc;
            cycle();
            check($sformatf("vec%0d.pc", i), pc_out, vecs[i].pc_out);
            check($sformatf("vec%0d.instr", i), instruction_out, vecs[i].instr);
            check($sformatf("vec%0d.valid", i), {31'h0, valid_out}, {31'h0, vecs[i].valid});
            check($sformatf("vec%0d.addr", i), imem_addr, vecs[i].addr);
            check($sformatf("vec%0d.scnt", i), stall_cnt, Perf ? vecs[i].scnt : 32'h0);
            check($sformatf("vec%0d.rcnt", i), redirect_cnt, Perf ? vecs[i].rcnt : 32'h0);
        end

        // Asynchronous reset mid-cycle while stalled at PC 0x40.
        do_reset();
        for (int i = 0; i < 16; i++) cycle();
        check("pre_stall.addr", imem_addr, 32'h40);
        stall = 1'b1;
        cycle();
        cycle();
        check("stalled.addr", imem_addr, 32'h40);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async.addr", imem_addr, 32'h0);
        check("async.pc", pc_out, 32'h0);
        check("async.instr", instruction_out, Nop);
        check("async.valid", {31'h0, valid_out}, 32'h0);
        check("async.scnt", stall_cnt, 32'h0);
        rst = 1'b0;
        stall = 1'b0;
        cycle();
        check("restart.pc", pc_out, 32'h0);
        check("restart.valid", {31'h0, valid_out}, 32'h1);
        check("restart.addr", imem_addr, 32'h4);

        // PC wrap from 0xFFFF_FFF8.
        @(posedge clk);
        #1;
        rst_w = 1'b0;
        @(posedge clk); #1;
        check("wrap0.pc", w_pc_out, 32'hFFFF_FFF8);
        check("wrap0.valid", {31'h0, w_valid}, 32'h1);
        @(posedge clk); #1;
        check("wrap1.pc", w_pc_out, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        check("wrap2.pc", w_pc_out, 32'h0000_0000);
        check("wrap2.instr", w_instr, Key);

        // Randomized stimulus against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 9) < 2);
            redirect_pc = $urandom;
            cycle();
            check_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch-side front end of the pipeline: owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline latch (PC, instruction, valid) that feeds the decode stage ahead of the ID/EX register. It supports a load-use stall from the hazard unit and a branch redirect/flush from the execute stage. It inserts canonical NOP bubbles so downstream control decodes to no side effects.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- imem_addr  output  32  fetch address; always equals current PC
- imem_rdata  input  32  instruction at imem_addr; combinational, same cycle
- stall  input  1  hold PC and IF/ID latch (load-use hazard)
- redirect  input  1  taken branch/jump resolved in EX
- redirect_pc  input  32  new fetch target; bits [1:0] ignored (treated as 0)
- pc_out  output  32  IF/ID latched PC
- instruction_out  output  32  IF/ID latched instruction
- valid_out  output  1  IF/ID latch holds a real instruction
- stall_cnt  output  32  stall-cycle counter (see Configuration)
- redirect_cnt  output  32  redirect counter (see Configuration)

## Operation
- The state consists of the PC register and the IF/ID latch: pc_out, instruction_out, valid_out.
- Per rising edge, priority is rst > redirect > stall > normal.
- **rst** (asynchronous): PC=RESET_PC, pc_out=0, instruction_out=NOP_INSTR, valid_out=0, counters=0.
- **redirect=1**: PC <= {redirect_pc[31:2],2'b00}.
  - IF/ID latch flushed: instruction_out <= NOP_INSTR, valid_out <= 0, pc_out <= 0.
  - This applies even if stall=1 in the same cycle; redirect wins.
- **stall=1, redirect=0**: PC and the whole IF/ID latch hold their values. imem_addr is unchanged.
- **Normal**:
  - pc_out <= PC, instruction_out <= imem_rdata, valid_out <= 1.
  - PC <= PC + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0 with no flag.
- While valid_out=0, instruction_out is always NOP_INSTR.
- No internal FSM beyond the valid bit. Fetch is stateless apart from the PC.

## Timing
- imem_addr = PC combinationally, with no extra register.
- Fetch-to-latch latency: 1 cycle. The instruction at PC appears on instruction_out after the next edge.
- First edge after rst deassert (no stall/redirect): pc_out=RESET_PC, valid_out=1.
- Redirect penalty: the edge sampling redirect produces one bubble. The next edge latches the instruction at redirect_pc.
- Stall is level-sensitive. N stall cycles freeze outputs for exactly N edges.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately (asynchronous), regardless of other inputs.
- Inputs are sampled only on the rising edge. Glitches between edges have no effect.

## Configuration
- Macro: IF_ID_PERF_CNT_EN.
- **Defined:**
  - stall_cnt increments on each edge with stall=1 and redirect=0.
  - redirect_cnt increments on each edge with redirect=1.
  - Both counters saturate at 32'hFFFF_FFFF and are cleared by rst.
- **Undefined:** stall_cnt and redirect_cnt are tied to 0, no counter flops are instantiated, and the port list is unchanged.

## Test plan
- Reset release, stall=0, imem returns addr^32'hA5A5_0000 → successive edges show pc_out=0,4,8 with matching instruction_out, valid_out=1; valid_out=0 before the first edge.
- stall=1 for 3 cycles at PC=8 → imem_addr stays 8; pc_out/instruction_out frozen for 3 edges; then pc_out=8 → 12 resumes. stall_cnt=3 with the macro defined, 0 without.
- redirect=1, redirect_pc=32'h0000_0103 with stall=1 in the same cycle → next edge: valid_out=0, instruction_out=32'h0000_0013, imem_addr=32'h0000_0100. Following edge: pc_out=32'h100, valid_out=1, redirect_cnt=1.
- RESET_PC=32'hFFFF_FFF8, run freely → pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst asynchronously mid-cycle while stalled at PC=32'h40 → outputs return to reset values before the next edge; fetch restarts from RESET_PC.
- Back-to-back redirects to 32'h200 then 32'h300 on consecutive edges → two bubbles; the next valid pc_out is 32'h300; 32'h200 is never latched valid.
